// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with registered responses, a refill FSM and per-set round-robin replacement.
// Optional hit/miss counters are compiled in when ICACHE_PERF_EN is defined.
module icache_assoc #(
    parameter int CACHE_SIZE = 8192,
    parameter int LINE_BITS  = 128,
    parameter int WAYS       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 read_en,
    output logic                 hit,
    output logic [31:0]          data_out,
    output logic                 data_valid,
    output logic [31:0]          mem_addr,
    output logic                 mem_req,
    input  logic [LINE_BITS-1:0] mem_data_in,
    input  logic                 mem_ready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);
    localparam int SETS     = CACHE_SIZE * 8 / (LINE_BITS * WAYS);
    localparam int OFFSET_W = $clog2(LINE_BITS / 32);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t                 state;
    logic [31:0]            req_addr;
    logic [WAYS-1:0]        valid_arr [SETS];
    logic [WAY_W-1:0]       rr_ptr    [SETS];
    logic [TAG_W-1:0]       tag_arr   [SETS][WAYS];
    logic [LINE_BITS-1:0]   data_arr  [SETS][WAYS];

    logic [INDEX_W-1:0]     lk_idx, rf_idx;
    logic [TAG_W-1:0]       lk_tag, rf_tag;
    logic [OFFSET_W-1:0]    lk_off, rf_off;
    logic                   hit_any, any_inv;
    logic [WAY_W-1:0]       hit_way, inv_way, victim;
    logic [31:0]            hit_word, mem_word;
    logic                   refill_done;

    assign lk_off = addr[OFFSET_W-1:0];
    assign lk_idx = addr[OFFSET_W +: INDEX_W];
    assign lk_tag = addr[31 -: TAG_W];
    assign rf_off = req_addr[OFFSET_W-1:0];
    assign rf_idx = req_addr[OFFSET_W +: INDEX_W];
    assign rf_tag = req_addr[31 -: TAG_W];

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[lk_idx][w] && tag_arr[lk_idx][w] == lk_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Scanning downward leaves the lowest-index invalid way selected.
    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[rf_idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        if (any_inv)
            victim = inv_way;
        else if (WAYS == 1)
            victim = '0;
        else
            victim = rr_ptr[rf_idx];
    end

    assign hit         = read_en && (state == IDLE) && hit_any;
    assign hit_word    = data_arr[lk_idx][hit_way][{lk_off, 5'b0} +: 32];
    assign mem_word    = mem_data_in[{rf_off, 5'b0} +: 32];
    assign refill_done = (state == REFILL) && mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    data_valid <= 1'b0;
                    if (read_en) begin
                        if (hit_any) begin
                            data_out   <= hit_word;
                            data_valid <= 1'b1;
                        end else begin
                            req_addr <= addr;
                            mem_addr <= {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
                            mem_req  <= 1'b1;
                            state    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        valid_arr[rf_idx][victim] <= 1'b1;
                        if (!any_inv && WAYS > 1)
                            rr_ptr[rf_idx] <= rr_ptr[rf_idx] + WAY_W'(1);
                        data_out   <= mem_word;
                        data_valid <= 1'b1;
                        mem_req    <= 1'b0;
                        state      <= RESPOND;
                    end
                end
                RESPOND: begin
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_arr[rf_idx][victim]  <= rf_tag;
            data_arr[rf_idx][victim] <= mem_data_in;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && read_en) begin
            if (hit_any) begin
                if (hit_count != 32'hFFFF_FFFF)
                    hit_count <= hit_count + 32'd1;
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: cold miss, hits, round-robin conflict, reset mid-refill, request change.
module tb_icache_assoc;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         read_en;
    logic         hit;
    logic [31:0]  data_out;
    logic         data_valid;
    logic [31:0]  mem_addr;
    logic         mem_req;
    logic [127:0] mem_data_in;
    logic         mem_ready;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    icache_assoc dut (
        .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .hit(hit),
        .data_out(data_out), .data_valid(data_valid), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_data_in(mem_data_in), .mem_ready(mem_ready)
`ifdef ICACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_line(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle miss with one wait cycle; caller sits at a negedge in IDLE.
    task automatic do_miss(input logic [31:0] a, input logic [127:0] line, input logic [31:0] exp);
        addr = a; read_en = 1'b1;
        #1 chk("miss_hit", 32'(hit), 32'd0);
        @(negedge clk);
        read_en = 1'b0;
        chk("miss_req", 32'(mem_req), 32'd1);
        chk("miss_maddr", mem_addr, {a[31:2], 2'b00});
        mem_ready = 1'b1; mem_data_in = line;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("miss_dv", 32'(data_valid), 32'd1);
        chk("miss_data", data_out, exp);
        @(negedge clk);
        chk("miss_dv_drop", 32'(data_valid), 32'd0);
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [31:0] exp);
        addr = a; read_en = 1'b1;
        #1 chk("hit_comb", 32'(hit), 32'd1);
        @(negedge clk);
        read_en = 1'b0;
        chk("hit_dv", 32'(data_valid), 32'd1);
        chk("hit_data", data_out, exp);
        chk("hit_noreq", 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1; addr = '0; read_en = 1'b0; mem_data_in = '0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_dout", data_out, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);

        // Cold miss on 0x105 with three memory wait cycles
        addr = 32'h105; read_en = 1'b1;
        #1 chk("cold_hit", 32'(hit), 32'd0);
        @(negedge clk);
        chk("cold_req", 32'(mem_req), 32'd1);
        chk("cold_maddr", mem_addr, 32'h104);
        @(negedge clk); @(negedge clk);
        chk("cold_req_held", 32'(mem_req), 32'd1);
        chk("cold_dv_wait", 32'(data_valid), 32'd0);
        mem_ready = 1'b1; mem_data_in = mk_line(32'hDEADBEEE);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("cold_dv", 32'(data_valid), 32'd1);
        chk("cold_data", data_out, 32'hDEADBEEF);
        chk("cold_req_drop", 32'(mem_req), 32'd0);
        chk("respond_nohit", 32'(hit), 32'd0);
        @(negedge clk);
        chk("idle_dv", 32'(data_valid), 32'd0);
        chk("rehit_comb", 32'(hit), 32'd1);
        @(negedge clk);
        chk("b2b_dv0", 32'(data_valid), 32'd1);
        chk("b2b_data0", data_out, 32'hDEADBEEF);
        addr = 32'h106;
        #1 chk("b2b_hit1", 32'(hit), 32'd1);
        @(negedge clk);
        read_en = 1'b0;
        chk("b2b_dv1", 32'(data_valid), 32'd1);
        chk("b2b_data1", data_out, 32'hDEADBEF0);
        chk("b2b_noreq", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("hold_dv", 32'(data_valid), 32'd0);
        chk("hold_data", data_out, 32'hDEADBEF0);

        // Conflict set 0x41: 0x105 in way0, 0x505 into way1, 0x905 evicts way0
        do_miss(32'h505, mk_line(32'h50500000), 32'h50500001);
        do_hit(32'h105, 32'hDEADBEEF);
        do_hit(32'h505, 32'h50500001);
        do_miss(32'h905, mk_line(32'h90900000), 32'h90900001);
        do_hit(32'h505, 32'h50500001);
        do_hit(32'h907, 32'h90900003);
        do_miss(32'h105, mk_line(32'hDEADBEEE), 32'hDEADBEEF);
        do_hit(32'h905, 32'h90900001);
        do_hit(32'h104, 32'hDEADBEEE);
        addr = 32'h505; read_en = 1'b1;
        #1 chk("rr_evict_505", 32'(hit), 32'd0);
        read_en = 1'b0;
        @(negedge clk);

        // Reset two cycles into a refill
        addr = 32'h305; read_en = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_maddr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0; read_en = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1; mem_data_in = mk_line(32'h30300000);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("late_ready_dv", 32'(data_valid), 32'd0);
        chk("late_ready_req", 32'(mem_req), 32'd0);
        addr = 32'h305; read_en = 1'b1;
        #1 chk("late_nofill", 32'(hit), 32'd0);
        addr = 32'h105;
        #1 chk("rst_cleared", 32'(hit), 32'd0);
        read_en = 1'b0;
        @(negedge clk);

        // Request changes while the refill is outstanding
        addr = 32'h105; read_en = 1'b1;
        @(negedge clk);
        addr = 32'h200;
        chk("chg_maddr0", mem_addr, 32'h104);
        @(negedge clk);
        chk("chg_maddr1", mem_addr, 32'h104);
        chk("chg_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_data_in = mk_line(32'hDEADBEEE);
        @(negedge clk);
        mem_ready = 1'b0; read_en = 1'b0;
        chk("chg_dv", 32'(data_valid), 32'd1);
        chk("chg_data", data_out, 32'hDEADBEEF);
        @(negedge clk);
        do_hit(32'h105, 32'hDEADBEEF);

`ifdef ICACHE_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("perf_rst_hits", hit_count, 32'd0);
        do_miss(32'h105, mk_line(32'hDEADBEEE), 32'hDEADBEEF);
        do_miss(32'h305, mk_line(32'h30300000), 32'h30300001);
        do_miss(32'h405, mk_line(32'h40400000), 32'h40400001);
        do_hit(32'h105, 32'hDEADBEEF);
        do_hit(32'h306, 32'h30300002);
        do_hit(32'h404, 32'h40400000);
        do_hit(32'h107, 32'hDEADBEF1);
        do_hit(32'h305, 32'h30300001);
        @(negedge clk);
        chk("perf_hits", hit_count, 32'd5);
        chk("perf_misses", miss_count, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
